// File: rtl/uart_rx_controller.sv
// uart_rx_controller: UART receive front end with 2-flop synchronizer, mid-bit sampling and break handling.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err reporting; otherwise 8N1 and parity_err is 0.
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       rx_in,
  input  logic       enable_serial,
  output logic [7:0] char_out,
  output logic       newChar,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] H_END = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] B_END = W'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rxs;
  logic [W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, char_n;
  logic new_n, ferr_n, perr_n;
  assign rxs = sync[1];
`ifdef UART_RX_PARITY_EN
  logic bad, bad_n;
  always_ff @(posedge sys_clk or posedge RST)
    if (RST) bad <= 1'b0;
    else bad <= bad_n;
`else
  logic bad;
  assign bad = 1'b0;
`endif
  always_ff @(posedge sys_clk or posedge RST)
    if (RST) sync <= 2'b11;
    else sync <= {sync[0], rx_in};
  always_ff @(posedge sys_clk or posedge RST)
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      char_out   <= '0;
      newChar    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      char_out   <= char_n;
      newChar    <= new_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    char_n  = char_out;
    new_n   = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_n   = bad;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START:
        if (cnt == H_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      DATA:
        if (cnt == B_END) begin
          cnt_n        = '0;
          shift_n[idx] = rxs;
          idx_n        = idx + 1'b1;
          if (&idx) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (cnt == B_END) begin
          cnt_n   = '0;
          bad_n   = rxs != ^shift;
          state_n = STOP;
        end
`endif
      STOP:
        if (cnt == B_END) begin
          // a low stop bit outranks parity and leaves us waiting for the line to recover
          cnt_n   = '0;
          state_n = rxs ? IDLE : BRK;
          ferr_n  = !rxs;
          perr_n  = rxs && bad;
          new_n   = rxs && !bad && enable_serial;
          char_n  = new_n ? shift : char_out;
        end
      BRK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Serial receive front end for the LED display's UART link. Samples the asynchronous `rx_in` line, deframes 8N1 characters (optionally 8E1), and presents each good byte on `char_out` with a one-cycle `newChar` strobe. Its outputs feed the echo transmitter and the display writer. Reception can be gated off while the display is being written.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): `sys_clk` cycles per bit. Legal minimum is 4.
- `sys_clk`  input  1  system clock; all logic on the rising edge.
- `RST`  input  1  asynchronous, active-high reset.
- `rx_in`  input  1  asynchronous serial line; idles high.
- `enable_serial`  input  1  when 0, completed frames are discarded (no `newChar`).
- `char_out`  output  8  last good received byte; held until the next good byte.
- `newChar`  output  1  one-cycle pulse: `char_out` was just updated.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied 0 without `UART_RX_PARITY_EN`.

## Operation
- `rx_in` passes through a 2-flop synchronizer (reset value 1). All decisions below use the synchronized value `rxs`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. Let H = `CLKS_PER_BIT/2`, using integer division.
- States:
  - **IDLE**: on `rxs`==0, clear the cycle counter and go to START.
  - **START**: count H cycles, then resample. If `rxs`==1 it was a glitch: return to IDLE with no outputs. Otherwise go to DATA with the bit index at 0.
  - **DATA**: every `CLKS_PER_BIT` cycles, sample `rxs` into `shift[idx]`, LSB first. After bit 7, go to PARITY (macro on) or STOP.
  - **PARITY**: after `CLKS_PER_BIT` cycles, sample. Error if the sample ≠ ^`shift` (even parity).
  - **STOP**: after `CLKS_PER_BIT` cycles, sample.
    - Sample 1, no parity error, `enable_serial`=1: `char_out`<=`shift`, pulse `newChar`.
    - Sample 1 with a parity error: pulse `parity_err`; `char_out` is unchanged.
    - Sample 0: pulse `frame_err`, discard the byte, go to BREAK.
    - Otherwise return to IDLE.
  - **BREAK**: wait until `rxs`==1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- `enable_serial` is only evaluated at the stop sample. Toggling it mid-frame never truncates the frame.
- When a frame is discarded because `enable_serial`=0, no error pulse is raised for a good frame.
- If `frame_err` and a parity error occur together, only `frame_err` is pulsed.
- Reset (any time, including mid-frame):
  - State goes to IDLE; counters and `shift` clear.
  - `char_out`=8'h00, `newChar`=0, `frame_err`=0, `parity_err`=0.
  - Synchronizer flops are set to 1.

## Timing
- Let T0 be the first `sys_clk` edge at which the raw `rx_in` is 0. Then `rxs` falls at T0+2.
- Sampling points:
  - Start check: T0+2+H.
  - Data bit k: T0+2+H+(k+1)·`CLKS_PER_BIT`.
  - Stop (8N1): T0+2+H+9·`CLKS_PER_BIT`. With parity it is one `CLKS_PER_BIT` later.
- `newChar`, `frame_err` and `parity_err` are registered and high exactly one cycle, the cycle after the stop sample. `char_out` changes on that same edge.
- After a good stop sample, IDLE is re-entered immediately. A following start bit is therefore accepted from the next cycle, so back-to-back frames with no idle gap are supported.
- Maximum tolerated baud mismatch is ±(H−2)/(9.5·`CLKS_PER_BIT`). No resynchronization occurs within a frame.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the frame is 8E1. The PARITY state exists and `parity_err` is driven.
  - Undefined: the frame is 8N1. The PARITY state is not compiled, and `parity_err` is constant 0.

## Test plan
- All scenarios use `CLKS_PER_BIT`=16 and macro undefined unless stated.
- Byte 8'h41 framed 8N1, `enable_serial`=1 -> one `newChar` pulse at T0+2+8+144+1, `char_out`=8'h41, no error pulses.
- Back-to-back 8'h0D then 8'h61 with zero idle between stop and start -> two `newChar` pulses 160 cycles apart; `char_out` reads 8'h0D then 8'h61.
- Glitch: `rx_in` low for 4 cycles -> no outputs; FSM is back in IDLE; a following 8'h33 is received correctly.
- Stop bit forced 0 on byte 8'h55, line then held low 100 cycles -> single `frame_err` pulse, `char_out` unchanged, no `newChar`; the next good frame is received.
- `RST` pulsed during data bit 3 -> all outputs 0 immediately; a subsequent 8'hA5 is received correctly.
- Macro defined: 8'h41 sent with parity bit 1 (wrong) -> `parity_err` pulse, no `newChar`. Same byte with parity 0 -> `newChar` with `char_out`=8'h41.
